// File: rtl/control_plane_mq_if.sv
// Control-plane bundle: GPP requests, control channel, data-plane flags.
// slave is the control plane itself; master drives its inputs.

interface control_plane_mq_if #(
  parameter int NODE_W = 8,
  parameter int LEN_W  = 16
);
  localparam int PKT_W = 2 * NODE_W + LEN_W;

  logic [NODE_W-1:0] node_id;
  logic [NODE_W-1:0] max_node;

  logic              tx_req;
  logic [NODE_W-1:0] tx_dest;
  logic [LEN_W-1:0]  tx_len;
  logic              tx_ack;
  logic              tx_err;
  logic              control_tx_valid;
  logic [PKT_W-1:0]  control_tx_packet;
  logic              data_tx_flag_out;
  logic [NODE_W-1:0] data_tx_node_id;
  logic              data_tx_complete;

  logic              control_rx_valid;
  logic [PKT_W-1:0]  control_rx_packet;
  logic              gpp_rtr;
  logic              data_rx_flag_out;
  logic [NODE_W-1:0] data_rx_node_id;
  logic [LEN_W-1:0]  data_rx_len;
  logic              data_rx_complete;
  logic              gpp_trf;
  logic              rx_timeout;
  logic              rxq_overflow;

  modport slave (
    input  node_id, max_node,
    input  tx_req, tx_dest, tx_len,
    output tx_ack, tx_err,
    output control_tx_valid, control_tx_packet,
    output data_tx_flag_out, data_tx_node_id,
    input  data_tx_complete,
    input  control_rx_valid, control_rx_packet,
    input  gpp_rtr,
    output data_rx_flag_out, data_rx_node_id,
    output data_rx_len,
    input  data_rx_complete,
    output gpp_trf, rx_timeout, rxq_overflow
  );

  modport master (
    output node_id, max_node,
    output tx_req, tx_dest, tx_len,
    input  tx_ack, tx_err,
    input  control_tx_valid, control_tx_packet,
    input  data_tx_flag_out, data_tx_node_id,
    output data_tx_complete,
    output control_rx_valid, control_rx_packet,
    output gpp_rtr,
    input  data_rx_flag_out, data_rx_node_id,
    input  data_rx_len,
    output data_rx_complete,
    input  gpp_trf, rx_timeout, rxq_overflow
  );
endinterface

// File: rtl/control_plane_mq.sv
// control_plane_mq: TDM-slotted control-channel access for one node,
// plus a buffered, timeout-guarded receive hand-off to the GPP.

module control_plane_mq #(
  parameter int NODE_W    = 8,
  parameter int LEN_W     = 16,
  parameter int PKT_W     = 2 * NODE_W + LEN_W,
  parameter int RXQ_DEPTH = 4,
  parameter int TIMEOUT   = 15
) (
  input logic clk,
  input logic rst,
  control_plane_mq_if.slave bus
);

  localparam int QA_W  = $clog2(RXQ_DEPTH);
  localparam int QE_W  = NODE_W + LEN_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [QA_W:0] Q_FULL = RXQ_DEPTH[QA_W:0];
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    T_IDLE,
    T_WAIT,
    T_DATA
  } tx_state_t;

  typedef enum logic {
    R_IDLE,
    R_BUSY
  } rx_state_t;

  // max_node of 0 behaves like a single-node ring
  logic [NODE_W-1:0] eff_max;
  logic [NODE_W-1:0] slot;

  assign eff_max = (bus.max_node == '0) ? NODE_W'(1) : bus.max_node;

  // TDM slot counter, wraps at eff_max-1
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot <= '0;
    end else if (eff_max <= NODE_W'(1) ||
                 slot >= eff_max - NODE_W'(1)) begin
      slot <= '0;
    end else begin
      slot <= slot + NODE_W'(1);
    end
  end

  tx_state_t         tx_state, tx_nxt;
  logic [NODE_W-1:0] dest_q, dest_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              ctv_q, ctv_d;
  logic [PKT_W-1:0]  pkt_q, pkt_d;
  logic              txf_q, txf_d;
  logic [NODE_W-1:0] txn_q, txn_d;

  // TX next state: accept/reject, wait for own slot, hold until done
  always_comb begin
    tx_nxt = tx_state;
    dest_d = dest_q;
    len_d  = len_q;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    ctv_d  = 1'b0;
    pkt_d  = pkt_q;
    txf_d  = txf_q;
    txn_d  = txn_q;
    unique case (tx_state)
      T_IDLE: begin
        if (bus.tx_req) begin
          if (bus.tx_dest == bus.node_id ||
              bus.tx_dest >= eff_max) begin
            err_d = 1'b1;
          end else begin
            dest_d = bus.tx_dest;
            len_d  = bus.tx_len;
            ack_d  = 1'b1;
            tx_nxt = T_WAIT;
          end
        end
      end
      T_WAIT: begin
        if (slot == bus.node_id) begin
          ctv_d  = 1'b1;
          pkt_d  = {dest_q, bus.node_id, len_q};
          txf_d  = 1'b1;
          txn_d  = dest_q;
          tx_nxt = T_DATA;
        end
      end
      T_DATA: begin
        if (bus.data_tx_complete) begin
          txf_d  = 1'b0;
          tx_nxt = T_IDLE;
        end
      end
      default: tx_nxt = T_IDLE;
    endcase
  end

  // TX state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= T_IDLE;
      dest_q   <= '0;
      len_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      ctv_q    <= 1'b0;
      pkt_q    <= '0;
      txf_q    <= 1'b0;
      txn_q    <= '0;
    end else begin
      tx_state <= tx_nxt;
      dest_q   <= dest_d;
      len_q    <= len_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      ctv_q    <= ctv_d;
      pkt_q    <= pkt_d;
      txf_q    <= txf_d;
      txn_q    <= txn_d;
    end
  end

  assign bus.tx_ack            = ack_q;
  assign bus.tx_err            = err_q;
  assign bus.control_tx_valid  = ctv_q;
  assign bus.control_tx_packet = pkt_q;
  assign bus.data_tx_flag_out  = txf_q;
  assign bus.data_tx_node_id   = txn_q;

  logic [NODE_W-1:0] rx_dest, rx_src;
  logic [LEN_W-1:0]  rx_len;
  logic [QE_W-1:0]   mem [RXQ_DEPTH];
  logic [QA_W-1:0]   wr_ptr, rd_ptr;
  logic [QA_W:0]     count;
  logic [QE_W-1:0]   head;
  logic              full, empty;
  logic              push, pop, wr_en;
  logic              ovf_q;
  rx_state_t         rx_state, rx_nxt;

  assign rx_dest = bus.control_rx_packet[PKT_W-1 -: NODE_W];
  assign rx_src  = bus.control_rx_packet[LEN_W +: NODE_W];
  assign rx_len  = bus.control_rx_packet[LEN_W-1:0];
  assign full    = (count == Q_FULL);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // only packets for us, and never our own echo
  assign push  = bus.control_rx_valid &&
                 rx_dest == bus.node_id &&
                 rx_src != bus.node_id;
  assign pop   = (rx_state == R_IDLE) && !empty && bus.gpp_rtr;
  // a same-edge pop frees the slot a full push needs
  assign wr_en = push && (!full || pop);

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {rx_src, rx_len};
    end
  end

  // RX FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + QA_W'(1);
      if (pop)   rd_ptr <= rd_ptr + QA_W'(1);
      if (wr_en && !pop) begin
        count <= count + (QA_W + 1)'(1);
      end else if (!wr_en && pop) begin
        count <= count - (QA_W + 1)'(1);
      end
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rxf_q, rxf_d;
  logic [NODE_W-1:0] rxn_q, rxn_d;
  logic [LEN_W-1:0]  rxl_q, rxl_d;
  logic              trf_q, trf_d;
  logic              to_q, to_d;

  // RX next state: hand head to GPP, finish on completion or timeout
  always_comb begin
    rx_nxt = rx_state;
    cnt_d  = cnt_q;
    rxf_d  = rxf_q;
    rxn_d  = rxn_q;
    rxl_d  = rxl_q;
    trf_d  = 1'b0;
    to_d   = 1'b0;
    unique case (rx_state)
      R_IDLE: begin
        if (pop) begin
          rxf_d  = 1'b1;
          rxn_d  = head[QE_W-1 -: NODE_W];
          rxl_d  = head[LEN_W-1:0];
          cnt_d  = '0;
          rx_nxt = R_BUSY;
        end
      end
      R_BUSY: begin
        if (bus.data_rx_complete) begin
          rxf_d  = 1'b0;
          trf_d  = 1'b1;
          rx_nxt = R_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rxf_d  = 1'b0;
          to_d   = 1'b1;
          rx_nxt = R_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: rx_nxt = R_IDLE;
    endcase
  end

  // RX state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= R_IDLE;
      cnt_q    <= '0;
      rxf_q    <= 1'b0;
      rxn_q    <= '0;
      rxl_q    <= '0;
      trf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      rx_state <= rx_nxt;
      cnt_q    <= cnt_d;
      rxf_q    <= rxf_d;
      rxn_q    <= rxn_d;
      rxl_q    <= rxl_d;
      trf_q    <= trf_d;
      to_q     <= to_d;
    end
  end

  assign bus.data_rx_flag_out = rxf_q;
  assign bus.data_rx_node_id  = rxn_q;
  assign bus.data_rx_len      = rxl_q;
  assign bus.gpp_trf          = trf_q;
  assign bus.rx_timeout       = to_q;
  assign bus.rxq_overflow     = ovf_q;

endmodule

// File: tb/tb_control_plane_mq.sv
// tb_control_plane_mq: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the node.

module tb_control_plane_mq;

  localparam int NW    = 8;
  localparam int LW    = 16;
  localparam int PW    = 2 * NW + LW;
  localparam int DEPTH = 4;
  localparam int TO    = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  control_plane_mq_if #(.NODE_W(NW), .LEN_W(LW)) bus ();

  control_plane_mq #(
    .NODE_W(NW), .LEN_W(LW), .PKT_W(PW),
    .RXQ_DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // model of what the outputs must be after each edge
  int                 age;
  int                 txph;
  logic [NW-1:0]      m_dest;
  logic [LW-1:0]      m_len;
  logic [NW+LW-1:0]   q[$];
  bit                 busy;
  int                 busy_for;
  logic               e_ack, e_err, e_ctv, e_txf;
  logic               e_rxf, e_trf, e_to, e_ovf;
  logic [PW-1:0]      e_pkt;
  logic [NW-1:0]      e_txn, e_rxn;
  logic [LW-1:0]      e_rxl;

  always @(posedge clk) begin : model
    int m;
    int slot_now;
    bit push, pop;
    logic [NW+LW-1:0] item;
    if (!rst) begin
      age = 0; txph = 0; busy = 0; busy_for = 0;
      m_dest = '0; m_len = '0; q.delete();
      e_ack = 0; e_err = 0; e_ctv = 0; e_txf = 0;
      e_rxf = 0; e_trf = 0; e_to = 0; e_ovf = 0;
      e_pkt = '0; e_txn = '0; e_rxn = '0; e_rxl = '0;
    end else begin
      m = (bus.max_node == 0) ? 1 : int'(bus.max_node);
      slot_now = age % m;
      e_ack = 0; e_err = 0; e_ctv = 0; e_trf = 0; e_to = 0;
      if (txph == 0) begin
        if (bus.tx_req) begin
          if (bus.tx_dest == bus.node_id || int'(bus.tx_dest) >= m) begin
            e_err = 1;
          end else begin
            e_ack = 1; m_dest = bus.tx_dest; m_len = bus.tx_len; txph = 1;
          end
        end
      end else if (txph == 1) begin
        if (slot_now == int'(bus.node_id)) begin
          e_ctv = 1; e_pkt = {m_dest, bus.node_id, m_len};
          e_txf = 1; e_txn = m_dest; txph = 2;
        end
      end else if (bus.data_tx_complete) begin
        e_txf = 0; txph = 0;
      end
      push = bus.control_rx_valid &&
             bus.control_rx_packet[PW-1 -: NW] == bus.node_id &&
             bus.control_rx_packet[LW +: NW] != bus.node_id;
      pop = !busy && q.size() > 0 && bus.gpp_rtr;
      if (busy) begin
        busy_for++;
        if (bus.data_rx_complete) begin
          e_trf = 1; e_rxf = 0; busy = 0;
        end else if (busy_for == TO) begin
          e_to = 1; e_rxf = 0; busy = 0;
        end
      end else if (pop) begin
        item = q.pop_front();
        e_rxf = 1; e_rxn = item[NW+LW-1 -: NW]; e_rxl = item[LW-1:0];
        busy = 1; busy_for = 0;
      end
      if (push) begin
        if (q.size() < DEPTH) q.push_back(bus.control_rx_packet[NW+LW-1:0]);
        else e_ovf = 1;
      end
      age++;
    end
  end

  // every-cycle comparison of DUT against the model
  always @(negedge clk) begin
    logic [39:0] act, exp_v;
    if (chk_en) begin
      act = {bus.tx_ack, bus.tx_err, bus.control_tx_valid,
             bus.data_tx_flag_out, bus.data_tx_node_id,
             bus.data_rx_flag_out, bus.data_rx_node_id, bus.data_rx_len,
             bus.gpp_trf, bus.rx_timeout, bus.rxq_overflow};
      exp_v = {e_ack, e_err, e_ctv, e_txf, e_txn, e_rxf, e_rxn, e_rxl,
               e_trf, e_to, e_ovf};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL model_outputs t=%0t got=%h want=%h", $time, act, exp_v);
      end
      if (e_ctv) begin
        total++;
        if (bus.control_tx_packet !== e_pkt) begin
          bad++;
          $display("FAIL model_packet t=%0t got=%h want=%h",
                   $time, bus.control_tx_packet, e_pkt);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, a, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    bus.tx_req = 0; bus.tx_dest = '0; bus.tx_len = '0;
    bus.data_tx_complete = 0; bus.control_rx_valid = 0;
    bus.control_rx_packet = '0; bus.gpp_rtr = 0; bus.data_rx_complete = 0;
  endtask

  task automatic rand_inputs();
    logic [NW-1:0] d;
    bus.tx_req = ($urandom_range(0, 9) < 3);
    bus.tx_dest = NW'($urandom_range(0, 7));
    bus.tx_len = LW'($urandom);
    bus.data_tx_complete = ($urandom_range(0, 4) == 0);
    bus.control_rx_valid = ($urandom_range(0, 9) < 4);
    d = ($urandom_range(0, 9) < 7) ? bus.node_id : NW'($urandom_range(0, 7));
    bus.control_rx_packet = {d, NW'($urandom_range(0, 7)), LW'($urandom)};
    bus.gpp_rtr = ($urandom_range(0, 9) < 7);
    bus.data_rx_complete = ($urandom_range(0, 11) == 0);
  endtask

  task automatic do_reset();
    logic [39:0] outs;
    rst = 0;
    repeat (3) begin
      rand_inputs();
      @(negedge clk);
    end
    outs = {bus.tx_ack, bus.tx_err, bus.control_tx_valid,
            bus.data_tx_flag_out, bus.data_tx_node_id,
            bus.data_rx_flag_out, bus.data_rx_node_id, bus.data_rx_len,
            bus.gpp_trf, bus.rx_timeout, bus.rxq_overflow};
    chk("reset_outputs", outs, 0);
    chk("reset_packet", bus.control_tx_packet, 0);
    idle();
    rst = 1;
  endtask

  task automatic wait_rxf(input string nm);
    int n = 0;
    while (!bus.data_rx_flag_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk(nm, 0, 1);
  endtask

  task automatic send_rx(input logic [PW-1:0] p);
    bus.control_rx_valid = 1;
    bus.control_rx_packet = p;
    tick(1);
    bus.control_rx_valid = 0;
  endtask

  initial begin
    @(posedge clk);
    #1 chk_en = 1;
  end

  initial begin
    int n;
    logic [NW-1:0] srcs [5];
    srcs = '{8'd2, 8'd3, 8'd0, 8'd2, 8'd3};
    idle();
    bus.node_id = 8'd1;
    bus.max_node = 8'd4;
    do_reset();

    // TX accept: slot 0 at the accept edge, slot 1 one edge later
    bus.tx_req = 1; bus.tx_dest = 8'd2; bus.tx_len = 16'h000F;
    tick(1);
    chk("tx_ack", bus.tx_ack, 1);
    bus.tx_req = 0;
    n = 0;
    while (!bus.control_tx_valid && n < 12) begin
      tick(1);
      n++;
    end
    chk("tx_latency", n, 1);
    chk("tx_packet", bus.control_tx_packet, 32'h0201000F);
    chk("tx_flag", bus.data_tx_flag_out, 1);
    chk("tx_node", bus.data_tx_node_id, 2);
    tick(3);
    chk("tx_flag_hold", bus.data_tx_flag_out, 1);
    bus.data_tx_complete = 1;
    tick(1);
    bus.data_tx_complete = 0;
    chk("tx_flag_clear", bus.data_tx_flag_out, 0);

    // TX rejects: own id, then out of range
    bus.tx_req = 1; bus.tx_dest = 8'd1;
    tick(1);
    chk("tx_err_self", {bus.tx_err, bus.tx_ack}, 2'b10);
    bus.tx_dest = 8'd4;
    tick(1);
    chk("tx_err_range", {bus.tx_err, bus.tx_ack}, 2'b10);
    bus.tx_req = 0;
    tick(6);

    // RX: one accepted packet, two filtered ones
    bus.gpp_rtr = 1;
    send_rx(32'h0103F0F0);
    chk("rx_flag_early", bus.data_rx_flag_out, 0);
    tick(1);
    chk("rx_flag", bus.data_rx_flag_out, 1);
    chk("rx_node", bus.data_rx_node_id, 3);
    chk("rx_len", bus.data_rx_len, 16'hF0F0);
    bus.data_rx_complete = 1;
    tick(1);
    bus.data_rx_complete = 0;
    chk("rx_trf", {bus.gpp_trf, bus.data_rx_flag_out}, 2'b10);
    send_rx(32'h0203F0F0);
    send_rx(32'h0101F0F0);
    tick(3);
    chk("rx_filtered", bus.data_rx_flag_out, 0);

    // overflow: five pushes into four entries, fifth dropped
    bus.gpp_rtr = 0;
    for (int k = 0; k < 5; k++) begin
      send_rx({8'd1, srcs[k], 16'(k + 1)});
    end
    chk("ovf_sticky", bus.rxq_overflow, 1);
    bus.gpp_rtr = 1;
    for (int k = 0; k < 4; k++) begin
      wait_rxf("ovf_wait");
      chk("ovf_order_src", bus.data_rx_node_id, srcs[k]);
      chk("ovf_order_len", bus.data_rx_len, k + 1);
      bus.data_rx_complete = 1;
      tick(1);
      bus.data_rx_complete = 0;
    end
    tick(4);
    chk("ovf_fifth_lost", bus.data_rx_flag_out, 0);

    // timeout: flag high for exactly TO cycles
    send_rx(32'h01020007);
    wait_rxf("to_wait");
    n = 0;
    while (bus.data_rx_flag_out && n < 40) begin
      n++;
      tick(1);
    end
    chk("to_cycles", n, 15);
    chk("to_pulse", {bus.rx_timeout, bus.gpp_trf}, 2'b10);
    tick(2);

    // completion on the last cycle beats the timeout
    send_rx(32'h01020008);
    wait_rxf("to2_wait");
    tick(14);
    chk("to2_flag_c15", bus.data_rx_flag_out, 1);
    bus.data_rx_complete = 1;
    tick(1);
    bus.data_rx_complete = 0;
    chk("to2_win", {bus.rx_timeout, bus.gpp_trf}, 2'b01);
    tick(3);

    // random traffic, re-reset with new topology each phase
    for (int ph = 0; ph < 6; ph++) begin
      bus.max_node = NW'($urandom_range(0, 7));
      bus.node_id = NW'($urandom_range(0, 7));
      do_reset();
      repeat (1500) begin
        rand_inputs();
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
